fp17_4lane_unpack: RTL and testbench
====================================

Name: fp17_4lane_unpack

Overview:
- Receiving end of the 4-lane fp17 bundle bus used in PDP.
- Accepts one 68-bit bundle (4 x 17-bit fp17 lanes, lane 0 in bits [16:0]) over valid/ready.
- Emits the lanes one per cycle on a 17-bit valid/ready stream, lane 0 first, with lane index and last-lane marker.
- Drains pooled fp17 results into per-element consumers such as the divide/scale and write-out stages.

Parameters:
- LANES, 4, number of lanes per bundle.
- DW, 17, width of one lane (fp17).
- CW, 3, width of the lane-count field; must hold the value LANES.

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  asynchronous active-low reset
- in_pvld  in  1  bundle valid
- in_prdy  out  1  bundle ready
- in_pd  in  LANES*DW  packed bundle, lane i at bits [i*DW +: DW]
- in_lane_num  in  CW  number of populated lanes, starting at lane 0
- out_pvld  out  1  lane valid
- out_prdy  in  1  lane ready
- out_pd  out  DW  lane data
- out_lane  out  2  index of the lane on out_pd
- out_last  out  1  out_pd is the final populated lane of the bundle
- clamp_err  out  1  sticky flag: an in_lane_num outside 1..LANES was seen

Behaviour:
- Reset (async assert, sync release) clears:
  - holding register data to 0, full to 0, lane counter to 0, stored count to 0, clamp_err to 0.
  - Out of reset: out_pvld=0, out_pd=0, out_lane=0, out_last=0, in_prdy=1.
- Storage: one holding register (data, stored count, full flag), plus a 2-bit lane counter cnt.
- Accept: in_pvld & in_prdy. Captures in_pd and the effective count, sets full, sets cnt=0.
- Effective count:
  - in_lane_num==0 or >LANES is replaced by LANES.
  - On such an accepted value, clamp_err is set. It stays set until reset.
- Output fields:
  - out_pvld = full.
  - out_pd = lane[cnt] of the held data; out_lane = cnt.
  - out_last = full & (cnt == stored count - 1).
  - All are driven from registers plus the cnt mux; they never depend combinationally on in_pd.
- Lane transfer: out_pvld & out_prdy.
  - Non-last lane: cnt increments.
  - Last lane: full clears, unless a new bundle is accepted in the same cycle.
- in_prdy = ~full | (out_pvld & out_prdy & out_last).
  - This is the only combinational path from out_prdy to in_prdy.
  - It gives zero-bubble back-to-back bundles.
- Latency: the first lane is valid the cycle after the bundle is accepted.
- Throughput: one lane per cycle. A bundle of n lanes occupies n cycles.
- States, implicit in full/cnt:
  - EMPTY (full=0).
  - SEND_k (full=1, cnt=k), k=0..stored count-1.
  - EMPTY -> SEND_0 on accept.
  - SEND_k -> SEND_k+1 on a non-last transfer.
  - Last SEND -> SEND_0 on transfer with a simultaneous accept; -> EMPTY on transfer without one.
- Stall: while out_pvld=1 & out_prdy=0, out_pd, out_lane and out_last hold stable and in_prdy=0.
- Count of 1: out_last is asserted on lane 0. The bundle drains in one cycle.
- Counter wrap: cnt never exceeds LANES-1. With the full count of 4, cnt=3 is last and the next bundle restarts at 0.
- Reset mid-bundle: the remaining lanes are discarded and the block returns to EMPTY.
- Unpopulated lanes are never emitted. Their data bits are ignored.

Decomposition:
- Shared pdp package holds:
  - the fp17 width constant (17) and the lane count (4);
  - the bundle width (68) and the lane-count field width (3);
  - lane-slice helper constants.
- Single module, no sub-module.
  - The holding register, counter and mux are too small to justify a split.
  - The valid/ready pipe stage is inline.

Test Plan:
- Reset then idle: out_pvld=0, in_prdy=1, clamp_err=0; release reset with in_pvld=0 -> outputs remain 0.
- in_pd = lanes {0x1ABCD, 0x00003, 0x0FFFF, 0x12345} (lane3..lane0), lane_num=4, out_prdy=1:
  - cycle+1..+4: out_pd = 0x12345, 0x0FFFF, 0x00003, 0x1ABCD;
  - out_lane = 0..3; out_last only on the 4th; in_prdy=1 on the 4th.
- Two bundles back-to-back, lane_num 4 then 2, out_prdy=1:
  - 6 consecutive lane beats with no bubble;
  - out_last on beats 4 and 6.
- lane_num=1 with out_prdy=1: a single beat with out_lane=0 and out_last=1; a second bundle is accepted in the same cycle.
- out_prdy toggled 1,0,0,1 mid-bundle:
  - out_pd and out_lane held during the zeros;
  - in_prdy=0 throughout;
  - no lane dropped or duplicated.
- lane_num=0, then lane_num=7:
  - each emits 4 lanes;
  - clamp_err rises after the first accept and stays set;
  - reset asserted mid-bundle at cnt=2 -> out_pvld=0 immediately, clamp_err=0.

Source files
------------

// File: rtl/fp17_4lane_unpack_pkg.sv
// Shared constants and types for the 4-lane fp17 bundle bus.
// Consumed by the unpack block, its interface and the bench.
package fp17_4lane_unpack_pkg;

  localparam int LANES = 4;
  localparam int DW    = 17;
  localparam int CW    = 3;
  localparam int LW    = 2;
  localparam int BW    = LANES * DW;

  typedef logic [DW-1:0] fp17_t;
  typedef logic [BW-1:0] bundle_t;
  typedef logic [CW-1:0] lane_num_t;
  typedef logic [LW-1:0] lane_idx_t;

  localparam lane_num_t LANES_NUM = lane_num_t'(LANES);

  function automatic fp17_t lane_sel(bundle_t b, lane_idx_t idx);
    return b[int'(idx)*DW +: DW];
  endfunction

  // Counts of zero or above LANES are treated as a full bundle.
  function automatic logic lane_num_bad(lane_num_t n);
    return (n == '0) || (n > LANES_NUM);
  endfunction

endpackage

// File: rtl/fp17_4lane_unpack_if.sv
// Bundle-in / lane-out handshake bundle for fp17_4lane_unpack.
// slave is the unpack block's view, master the producer/consumer side.
interface fp17_4lane_unpack_if;
  import fp17_4lane_unpack_pkg::*;

  logic      in_pvld;
  logic      in_prdy;
  bundle_t   in_pd;
  lane_num_t in_lane_num;

  logic      out_pvld;
  logic      out_prdy;
  fp17_t     out_pd;
  lane_idx_t out_lane;
  logic      out_last;

  modport slave (
    input  in_pvld, in_pd, in_lane_num, out_prdy,
    output in_prdy, out_pvld, out_pd, out_lane, out_last
  );

  modport master (
    output in_pvld, in_pd, in_lane_num, out_prdy,
    input  in_prdy, out_pvld, out_pd, out_lane, out_last
  );

endinterface

// File: rtl/fp17_4lane_unpack.sv
// Unpacks a 4 x fp17 bundle into one lane per cycle, lane 0 first; first lane one cycle after accept.
// Single holding register; in_prdy reopens combinationally on the last lane transfer for zero-bubble bundles.
module fp17_4lane_unpack
  import fp17_4lane_unpack_pkg::*;
(
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  fp17_4lane_unpack_if.slave  bus,
  output logic                clamp_err
);

  bundle_t   data_q,  data_d;
  lane_num_t num_q,   num_d;
  lane_idx_t cnt_q,   cnt_d;
  logic      full_q,  full_d;
  logic      clamp_q, clamp_d;

  logic accept;
  logic xfer;
  logic last;

  assign last   = full_q & ({1'b0, cnt_q} == (num_q - lane_num_t'(1)));
  assign xfer   = full_q & bus.out_prdy;

  assign bus.in_prdy  = ~full_q | (xfer & last);
  assign accept       = bus.in_pvld & bus.in_prdy;

  assign bus.out_pvld = full_q;
  assign bus.out_pd   = lane_sel(data_q, cnt_q);
  assign bus.out_lane = cnt_q;
  assign bus.out_last = last;
  assign clamp_err    = clamp_q;

  always_comb begin
    data_d  = data_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    clamp_d = clamp_q;
    // An accept can only coincide with the last-lane transfer, so it takes priority.
    if (accept) begin
      data_d = bus.in_pd;
      num_d  = lane_num_bad(bus.in_lane_num) ? LANES_NUM : bus.in_lane_num;
      cnt_d  = '0;
      full_d = 1'b1;
      if (lane_num_bad(bus.in_lane_num)) begin
        clamp_d = 1'b1;
      end
    end else if (xfer) begin
      if (last) begin
        full_d = 1'b0;
      end else begin
        cnt_d = cnt_q + lane_idx_t'(1);
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      data_q  <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      clamp_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      clamp_q <= clamp_d;
    end
  end

endmodule

// File: tb/tb_fp17_4lane_unpack.sv
// Scoreboard bench for fp17_4lane_unpack: driver queues expected lanes at accept, monitor checks each beat.
module tb_fp17_4lane_unpack;
  import fp17_4lane_unpack_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic clamp_err;

  fp17_4lane_unpack_if bus();

  fp17_4lane_unpack dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .bus             (bus),
    .clamp_err       (clamp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    fp17_t     pd;
    lane_idx_t lane;
    logic      last;
  } beat_t;

  beat_t exp_q[$];
  int    beat_cyc[$];
  int    checks = 0;
  int    fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented lane is compared against the head of the queue.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rstn && bus.out_pvld) begin
        chk("beat_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          chk("out_pd",   bus.out_pd,   e.pd);
          chk("out_lane", bus.out_lane, e.lane);
          chk("out_last", bus.out_last, e.last);
          if (bus.out_prdy) begin
            chk("in_prdy_on_beat", bus.in_prdy, e.last);
            void'(exp_q.pop_front());
            beat_cyc.push_back(cyc);
          end else begin
            chk("in_prdy_stall", bus.in_prdy, 0);
          end
        end
      end
    end
  end

  task automatic send(input fp17_t l0, input fp17_t l1, input fp17_t l2, input fp17_t l3,
                      input lane_num_t num, input int n, output int acc);
    fp17_t lanes [4];
    beat_t b;
    lanes[0] = l0; lanes[1] = l1; lanes[2] = l2; lanes[3] = l3;
    bus.in_pd       = {l3, l2, l1, l0};
    bus.in_lane_num = num;
    bus.in_pvld     = 1'b1;
    acc = -1;
    for (int t = 0; t < 50 && acc < 0; t++) begin
      @(negedge clk);
      if (bus.in_prdy) begin
        acc = cyc;
        for (int i = 0; i < n; i++) begin
          b.pd   = lanes[i];
          b.lane = lane_idx_t'(i);
          b.last = (i == n - 1);
          exp_q.push_back(b);
        end
      end
      @(posedge clk); #1;
    end
    bus.in_pvld = 1'b0;
    chk("accept_in_time", 32'(acc >= 0), 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, acc_d, n0;
    bus.in_pvld     = 1'b0;
    bus.in_pd       = '0;
    bus.in_lane_num = '0;
    bus.out_prdy    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_pvld", bus.out_pvld, 0);
    chk("rst_in_prdy",  bus.in_prdy,  1);
    chk("rst_clamp",    clamp_err,    0);
    chk("rst_out_pd",   bus.out_pd,   0);
    chk("rst_out_lane", bus.out_lane, 0);
    chk("rst_out_last", bus.out_last, 0);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_out_pvld", bus.out_pvld, 0);
    chk("idle_in_prdy",  bus.in_prdy,  1);
    chk("idle_out_pd",   bus.out_pd,   0);
    chk("idle_out_last", bus.out_last, 0);
    @(posedge clk); #1;

    // Single full bundle; first lane valid the cycle after accept
    bus.out_prdy = 1'b1;
    send(17'h12345, 17'h0FFFF, 17'h00003, 17'h1ABCD, 3'd4, 4, acc);
    @(negedge clk);
    chk("latency_out_pvld", bus.out_pvld, 1);
    chk("latency_out_lane", bus.out_lane, 0);
    drain();

    // Back-to-back 4 then 2: six beats, no bubble
    n0 = beat_cyc.size();
    send(17'h00011, 17'h00022, 17'h00033, 17'h00044, 3'd4, 4, acc);
    send(17'h1F000, 17'h0A5A5, 17'h15555, 17'h15555, 3'd2, 2, acc);
    drain();
    chk("b2b_beats", beat_cyc.size() - n0, 6);
    if (beat_cyc.size() - n0 == 6) chk("b2b_span", beat_cyc[n0+5] - beat_cyc[n0], 5);

    // Count of 1, next bundle accepted in the same cycle as its only beat
    n0 = beat_cyc.size();
    send(17'h0BEEF, 17'h1DEAD, 17'h1DEAD, 17'h1DEAD, 3'd1, 1, acc);
    send(17'h00777, 17'h10001, 17'h1DEAD, 17'h1DEAD, 3'd2, 2, acc_d);
    drain();
    chk("one_lane_beats", beat_cyc.size() - n0, 3);
    if (beat_cyc.size() - n0 == 3) chk("one_lane_same_cycle_accept", beat_cyc[n0], acc_d);

    // Stall pattern 1,0,0,1 mid-bundle
    n0 = beat_cyc.size();
    send(17'h00101, 17'h00202, 17'h00303, 17'h00404, 3'd4, 4, acc);
    @(posedge clk); #1 bus.out_prdy = 1'b0;
    @(posedge clk); #1 bus.out_prdy = 1'b0;
    @(posedge clk); #1 bus.out_prdy = 1'b1;
    drain();
    chk("stall_beats", beat_cyc.size() - n0, 4);
    if (beat_cyc.size() - n0 == 4) chk("stall_span", beat_cyc[n0+3] - beat_cyc[n0], 5);

    // Clamped counts 0 and 7 both emit four lanes; clamp_err is sticky
    chk("clamp_before", clamp_err, 0);
    send(17'h1000A, 17'h1000B, 17'h1000C, 17'h1000D, 3'd0, 4, acc);
    @(negedge clk);
    chk("clamp_after_zero", clamp_err, 1);
    drain();
    send(17'h0070A, 17'h0070B, 17'h0070C, 17'h0070D, 3'd7, 4, acc);
    drain();
    chk("clamp_after_seven", clamp_err, 1);

    // Reset while lane 2 is presented
    send(17'h0AAA0, 17'h0AAA1, 17'h0AAA2, 17'h0AAA3, 3'd4, 4, acc);
    @(posedge clk);
    @(posedge clk); #1 bus.out_prdy = 1'b0;
    @(negedge clk);
    chk("midrst_lane_before", bus.out_lane, 2);
    chk("midrst_pending",     exp_q.size(), 2);
    #1 rstn = 1'b0;
    #1;
    chk("midrst_out_pvld", bus.out_pvld, 0);
    chk("midrst_clamp",    clamp_err,    0);
    chk("midrst_in_prdy",  bus.in_prdy,  1);
    exp_q.delete();
    @(posedge clk); #1 rstn = 1'b1;
    bus.out_prdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_out_pvld", bus.out_pvld, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
